instr_fetch_unit: RTL

Instruction fetch stage for the RISC-V single-cycle core. Holds the architectural PC, issues ready-handshaked requests to instruction memory, and presents the fetched instruction, its PC, PC+4 and `OP_Code` to the main decoder and datapath. It applies the branch/jump redirect (`PCSrc`/`PCTarget`) from the execute logic and supports back-to-back fetch when memory answers in the same cycle.

---
 rtl/riscv_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 14 +
 rtl/next_pc_sel.sv | 25 ++
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: base opcodes, the canonical NOP and the fetch FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_ERROR = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory request channel: the fetch unit is master, the memory is slave.
interface instr_fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            IMemReq;
  logic [XLEN-1:0] IMemAddr;
  logic            IMemRdy;
  logic [31:0]     IMemData;

  modport master (output IMemReq, output IMemAddr, input IMemRdy, input IMemData);
  modport slave  (input IMemReq, input IMemAddr, output IMemRdy, output IMemData);

endinterface

// File: rtl/next_pc_sel.sv
// Purpose: selects the next fetch address (redirect target or PC+4) and flags misalignment.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when the result is consumed.
module next_pc_sel
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_pc_src,
  input  logic [XLEN-1:0] i_pc_target,
  output logic [XLEN-1:0] o_pc_plus4,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_next_pc;

  // Wraps naturally at 2^XLEN.
  assign o_pc_plus4   = i_pc + XLEN'(4);
  assign w_next_pc    = i_pc_src ? i_pc_target : o_pc_plus4;
  assign o_next_pc    = w_next_pc;
  assign o_misaligned = |w_next_pc[1:0];

endmodule

// File: rtl/instr_fetch_unit.sv
// Purpose: fetch stage holding the architectural PC and the registered instruction.
// Latency: one cycle from accepted request to InstrValid; back-to-back when IMemRdy stays high.
// Backpressure: IMemRdy low parks in FETCH with the address frozen; Stall holds EXEC, no request.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PCSrc,
  input  logic [XLEN-1:0]      PCTarget,
  input  logic                 Stall,
  instr_fetch_unit_if.master   imem,
  output logic [31:0]          Instr,
  output logic [6:0]           OP_Code,
  output logic [XLEN-1:0]      PC,
  output logic [XLEN-1:0]      PCPlus4,
  output logic                 InstrValid,
  output logic                 FetchErr
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_pc;
  logic [31:0]     r_instr;
  logic            r_valid;
  logic            r_err;

  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_next_pc;
  logic            w_misaligned;
  logic            w_req;
  logic [XLEN-1:0] w_addr;

  next_pc_sel #(.XLEN(XLEN)) u_next_pc_sel (
    .i_pc         (r_pc),
    .i_pc_src     (PCSrc),
    .i_pc_target  (PCTarget),
    .o_pc_plus4   (w_pc_plus4),
    .o_next_pc    (w_next_pc),
    .o_misaligned (w_misaligned)
  );

  // In EXEC the request goes out speculatively on NextPC so a ready memory gives zero bubbles.
  always_comb begin
    w_req  = 1'b0;
    w_addr = r_fetch_pc;
    case (r_state)
      ST_FETCH: w_req = 1'b1;
      ST_EXEC: begin
        if (!Stall && !w_misaligned) begin
          w_req  = 1'b1;
          w_addr = w_next_pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_pc       <= RESET_PC;
      r_instr    <= NOP_INSTR;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state    <= ST_FETCH;
          r_fetch_pc <= RESET_PC;
        end
        ST_FETCH: begin
          if (imem.IMemRdy) begin
            r_instr <= imem.IMemData;
            r_pc    <= r_fetch_pc;
            r_valid <= 1'b1;
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!Stall) begin
            if (w_misaligned) begin
              r_valid <= 1'b0;
              r_err   <= 1'b1;
              r_state <= ST_ERROR;
            end else if (imem.IMemRdy) begin
              r_instr <= imem.IMemData;
              r_pc    <= w_next_pc;
            end else begin
              r_fetch_pc <= w_next_pc;
              r_valid    <= 1'b0;
              r_state    <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_ERROR;
      endcase
    end
  end

  assign imem.IMemReq  = w_req;
  assign imem.IMemAddr = w_addr;
  assign Instr         = r_instr;
  assign OP_Code       = r_instr[6:0];
  assign PC            = r_pc;
  assign PCPlus4       = w_pc_plus4;
  assign InstrValid    = r_valid;
  assign FetchErr      = r_err;

endmodule
